xor_cipher_ctrl: RTL and testbench
==================================

Name: xor_cipher_ctrl

Overview:
- Sequencer between the UART receive FIFO, the XOR cipher datapath and the UART transmit FIFO.
- Pops each received byte and either stores it into the key buffer (key-load mode) or XORs it with the next key byte and pushes the result to the TX FIFO.
- The UART tick generators and FIFOs are external.
- This block owns the key storage, the key index and the read/write handshakes.

Parameters:
- DW, 8, data byte width.
- KMAX, 16, maximum key length in bytes.
- KW, 4, key index width; KMAX = 2**KW.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- key_mode  in  1  level; 1 = received bytes are key material, 0 = received bytes are ciphered. Synchronous to clk.
- rx_empty  in  1  RX FIFO empty flag.
- rx_data  in  DW  RX FIFO head word; first-word-fall-through, valid while rx_empty = 0.
- rd_uart  out  1  RX FIFO pop strobe, one cycle per byte.
- tx_full  in  1  TX FIFO full flag.
- wr_uart  out  1  TX FIFO push strobe, one cycle per byte.
- tx_data  out  DW  byte to TX FIFO; valid when wr_uart = 1.
- key_len  out  KW+1  number of valid key bytes, 0..KMAX.
- key_ovf  out  1  sticky; set when key bytes beyond KMAX are discarded.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is clk.
- Reset values:
  - State = IDLE.
  - rd_uart = 0, wr_uart = 0, tx_data = 0, key_len = 0, key_ovf = 0, busy = 0.
  - Key index idx = 0, write pointer wptr = 0, last_mode = 0.
  - Key array contents are don't-care.
- FSM states: IDLE, POP, KEYWR, XOR, SEND.
- IDLE:
  - rx_empty = 0 -> POP.
  - Otherwise stay.
- POP (exactly 1 cycle):
  - rd_uart = 1.
  - byte_reg <= rx_data; mode_reg <= key_mode.
  - Next state: KEYWR if key_mode = 1, else XOR.
- KEYWR (1 cycle):
  - New session (mode_reg = 1 and last_mode = 0): key_len <= 1, key_ovf <= 0, key[0] <= byte_reg, wptr <= 1.
  - Otherwise, if wptr < KMAX: key[wptr] <= byte_reg, wptr <= wptr+1, key_len <= wptr+1.
  - Otherwise: byte discarded, key_ovf <= 1.
  - Always: idx <= 0, last_mode <= 1.
  - Next state: IDLE.
- XOR (1 cycle):
  - last_mode <= 0.
  - If key_len = 0: tx_data <= byte_reg (passthrough).
  - Else: tx_data <= byte_reg ^ key[idx]; idx <= (idx = key_len-1) ? 0 : idx+1.
  - Next state: SEND.
- SEND:
  - wr_uart = (tx_full = 0), combinational from the state register and tx_full.
  - On tx_full = 0 -> IDLE.
  - While tx_full = 1: hold; tx_data stable; no push.
- rd_uart and wr_uart are never asserted in the same cycle.
- At most one byte is in flight.
- key_mode is sampled only in POP; toggling it at any other time has no effect on the byte in flight.
- Latency: rx_empty falls in cycle 0 (IDLE) -> rd_uart in cycle 1 -> XOR in cycle 2 -> wr_uart in cycle 3 when tx_full = 0.
- Throughput: 1 byte per 4 cycles.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - A pending SEND produces no push.
  - A byte already popped is lost.
  - key_len = 0 after reset, so following bytes pass through unchanged.

Test Plan:
- Reset then idle, rx_empty = 1 for 10 cycles -> rd_uart = 0, wr_uart = 0, busy = 0, key_len = 0, tx_data = 0.
- key_len = 0, push 0x41 -> rd_uart in cycle 1, wr_uart in cycle 3, tx_data = 0x41.
- key_mode = 1, bytes 0x5A, 0xA5 -> key_len = 2, no wr_uart. Then key_mode = 0, bytes 0x00, 0x00, 0xFF -> tx_data 0x5A, 0xA5, 0xA5 (idx wraps to 0 on the third byte).
- Cipher byte with tx_full = 1 held 5 cycles in SEND -> wr_uart = 0 throughout, tx_data stable. Exactly one push, in the cycle tx_full drops.
- KMAX = 16, key_mode = 1 for 17 bytes -> key_len = 16, key_ovf = 1. New key session with 0x0F -> key_len = 1, key_ovf = 0, next cipher byte 0xF0 -> 0xFF.
- Assert rst during SEND -> no wr_uart. After release, key_len = 0 and the next byte 0x33 is output as 0x33.

Source files
------------

// File: rtl/xor_cipher_ctrl.sv
// xor_cipher_ctrl: sequences RX FIFO bytes into a key buffer or through an XOR cipher to the TX FIFO.
module xor_cipher_ctrl #(
    parameter int DW   = 8,
    parameter int KMAX = 16,
    parameter int KW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_mode,
    input  logic          rx_empty,
    input  logic [DW-1:0] rx_data,
    output logic          rd_uart,
    input  logic          tx_full,
    output logic          wr_uart,
    output logic [DW-1:0] tx_data,
    output logic [KW:0]   key_len,
    output logic          key_ovf,
    output logic          busy
);
    typedef enum logic [2:0] {IDLE, POP, KEYWR, XOR, SEND} state_t;

    localparam logic [KW:0]   ONE    = (KW+1)'(1);
    localparam logic [KW:0]   KMAX_W = (KW+1)'(KMAX);
    localparam logic [KW-1:0] IDX1   = KW'(1);

    state_t        state;
    logic [DW-1:0] byte_reg;
    logic          mode_reg;
    logic          last_mode;
    logic [KW:0]   wptr;
    logic [KW-1:0] idx;
    logic [DW-1:0] key [KMAX];

    logic          new_sess;
    logic          key_we;
    logic [KW-1:0] key_wa;
    logic          idx_wrap;

    // A key session starts on the first key byte following cipher traffic (or reset)
    assign new_sess = mode_reg && !last_mode;
    assign key_we   = (state == KEYWR) && (new_sess || wptr < KMAX_W);
    assign key_wa   = new_sess ? '0 : wptr[KW-1:0];
    assign idx_wrap = {1'b0, idx} == key_len - ONE;
    assign wr_uart  = (state == SEND) && !tx_full;
    assign busy     = state != IDLE;

    always_ff @(posedge clk)
        if (key_we) key[key_wa] <= byte_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_uart   <= 1'b0;
            tx_data   <= '0;
            key_len   <= '0;
            key_ovf   <= 1'b0;
            idx       <= '0;
            wptr      <= '0;
            last_mode <= 1'b0;
            byte_reg  <= '0;
            mode_reg  <= 1'b0;
        end else begin
            rd_uart <= (state == IDLE) && !rx_empty;
            case (state)
                IDLE: if (!rx_empty) state <= POP;
                POP: begin
                    byte_reg <= rx_data;
                    mode_reg <= key_mode;
                    state    <= key_mode ? KEYWR : XOR;
                end
                KEYWR: begin
                    if (new_sess) begin
                        key_len <= ONE;
                        key_ovf <= 1'b0;
                        wptr    <= ONE;
                    end else if (wptr < KMAX_W) begin
                        wptr    <= wptr + ONE;
                        key_len <= wptr + ONE;
                    end else begin
                        key_ovf <= 1'b1;
                    end
                    idx       <= '0;
                    last_mode <= 1'b1;
                    state     <= IDLE;
                end
                XOR: begin
                    last_mode <= 1'b0;
                    if (key_len == '0) begin
                        tx_data <= byte_reg;
                    end else begin
                        tx_data <= byte_reg ^ key[idx];
                        idx     <= idx_wrap ? '0 : idx + IDX1;
                    end
                    state <= SEND;
                end
                SEND: if (!tx_full) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// tb_xor_cipher_ctrl: directed vectors with hand-computed expectations for xor_cipher_ctrl.
module tb_xor_cipher_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rd_uart;
    logic       tx_full = 1'b0;
    logic       wr_uart;
    logic [7:0] tx_data;
    logic [4:0] key_len;
    logic       key_ovf;
    logic       busy;

    int checks = 0;
    int failures = 0;

    xor_cipher_ctrl #(.DW(8), .KMAX(16), .KW(4)) dut (
        .clk(clk), .rst(rst), .key_mode(key_mode), .rx_empty(rx_empty), .rx_data(rx_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .tx_data(tx_data),
        .key_len(key_len), .key_ovf(key_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one byte and runs until the controller is idle again, bounded at 20 cycles.
    task automatic xfer(input logic [7:0] b, input logic km, output logic [7:0] got,
                        output int rd_cyc, output int wr_cyc, output int wr_cnt, output logic clash);
        got = 8'hxx; rd_cyc = 0; wr_cyc = 0; wr_cnt = 0; clash = 1'b0;
        rx_data = b; key_mode = km; rx_empty = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (rd_uart && wr_uart) clash = 1'b1;
            if (rd_uart) begin rd_cyc = c; rx_empty = 1'b1; end
            if (wr_uart) begin wr_cnt++; wr_cyc = c; got = tx_data; end
            if (rd_cyc > 0 && !rd_uart && !busy) break;
        end
        rx_empty = 1'b1;
        if (rd_cyc == 0) chk("xfer_timeout", 0, 1);
    endtask

    logic [7:0] got, held;
    int rd_cyc, wr_cyc, wr_cnt;
    logic clash, act;

    initial begin
        repeat (2) step();
        rst = 1'b0;
        act = 1'b0;
        repeat (10) begin
            step();
            act |= rd_uart | wr_uart | busy;
        end
        chk("idle_activity", act, 0);
        chk("rst_key_len", key_len, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_key_ovf", key_ovf, 0);

        xfer(8'h41, 1'b0, got, rd_cyc, wr_cyc, wr_cnt, clash);
        chk("pass_rd_cyc", rd_cyc, 1);
        chk("pass_wr_cyc", wr_cyc, 3);
        chk("pass_data", got, 8'h41);
        chk("pass_wr_cnt", wr_cnt, 1);
        chk("pass_clash", clash, 0);

        xfer(8'h5A, 1'b1, got, rd_cyc, wr_cyc, wr_cnt, clash);
        chk("key0_wr_cnt", wr_cnt, 0);
        xfer(8'hA5, 1'b1, got, rd_cyc, wr_cyc, wr_cnt, clash);
        chk("key1_wr_cnt", wr_cnt, 0);
        chk("key2_len", key_len, 2);
        xfer(8'h00, 1'b0, got, rd_cyc, wr_cyc, wr_cnt, clash);
        chk("cip0", got, 8'h5A);
        xfer(8'h00, 1'b0, got, rd_cyc, wr_cyc, wr_cnt, clash);
        chk("cip1", got, 8'hA5);
        xfer(8'hFF, 1'b0, got, rd_cyc, wr_cyc, wr_cnt, clash);
        chk("cip2_wrap", got, 8'hA5);

        // idx now 1 -> key[1]=A5; 0F^A5 = AA
        tx_full = 1'b1;
        rx_data = 8'h0F; key_mode = 1'b0; rx_empty = 1'b0;
        step();
        step();
        rx_empty = 1'b1;
        step();
        chk("full_in_send", busy, 1);
        held = tx_data;
        act = 1'b0;
        repeat (5) begin
            step();
            act |= wr_uart | (tx_data !== held);
        end
        chk("full_hold", act, 0);
        chk("full_data", held, 8'hAA);
        tx_full = 1'b0;
        #1;
        chk("full_release_wr", wr_uart, 1);
        step();
        chk("full_after_wr", wr_uart, 0);
        chk("full_after_busy", busy, 0);

        for (int i = 0; i < 17; i++)
            xfer(8'h10 + 8'(i), 1'b1, got, rd_cyc, wr_cyc, wr_cnt, clash);
        chk("ovf_len", key_len, 16);
        chk("ovf_flag", key_ovf, 1);
        xfer(8'h00, 1'b0, got, rd_cyc, wr_cyc, wr_cnt, clash);
        chk("ovf_key0", got, 8'h10);
        xfer(8'h0F, 1'b1, got, rd_cyc, wr_cyc, wr_cnt, clash);
        chk("sess_len", key_len, 1);
        chk("sess_ovf", key_ovf, 0);
        xfer(8'hF0, 1'b0, got, rd_cyc, wr_cyc, wr_cnt, clash);
        chk("sess_cip", got, 8'hFF);

        tx_full = 1'b1;
        rx_data = 8'h77; key_mode = 1'b0; rx_empty = 1'b0;
        step();
        rx_empty = 1'b1;
        step();
        step();
        chk("prerst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_no_wr", wr_uart, 0);
        tx_full = 1'b0;
        #1;
        chk("rst_no_wr_free", wr_uart, 0);
        step();
        rst = 1'b0;
        chk("rst_len", key_len, 0);
        chk("rst_busy", busy, 0);
        xfer(8'h33, 1'b0, got, rd_cyc, wr_cyc, wr_cnt, clash);
        chk("rst_pass", got, 8'h33);
        chk("rst_pass_cnt", wr_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
